// File: rtl/fifo_1w1r.sv
// Single-clock valid/ready FIFO in front of a 1W1R storage array.
// The read address is registered from the next read pointer, so out_data shows the head entry with no extra latency.
module fifo_1w1r #(
    parameter int DEPTH_W = 4,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [DEPTH_W:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0]   FULL_COUNT = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0]   COUNT_ONE  = 1;
    localparam logic [DEPTH_W-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0]   storage [DEPTH];
    logic [DEPTH_W-1:0] wptr;
    logic [DEPTH_W-1:0] rptr;
    logic [DEPTH_W-1:0] rptr_next;
    logic [DEPTH_W-1:0] raddr;
    logic               push;
    logic               pop;

    assign in_ready  = (count != FULL_COUNT) && !rst && !flush;
    assign out_valid = (count != '0) && !rst && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Clearing events force the read address back to slot 0 alongside the pointers.
    always_comb begin
        rptr_next = rptr;
        if (rst || flush) begin
            rptr_next = '0;
        end else if (pop) begin
            rptr_next = rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            storage[wptr] <= in_data;
        end
    end

    assign out_data = storage[raddr];

    always_ff @(posedge clk) begin
        raddr <= rptr_next;
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Sticky error flags survive flush; only reset clears them.
            if (in_valid && (count == FULL_COUNT)) begin
                overflow <= 1'b1;
            end
            if (out_ready && (count == '0) && !flush) begin
                underflow <= 1'b1;
            end
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + PTR_ONE;
                end
                rptr <= rptr_next;
                if (push && !pop) begin
                    count <= count + COUNT_ONE;
                end else if (pop && !push) begin
                    count <= count - COUNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_1w1r.sv
// Directed testbench for fifo_1w1r: a queue-based reference model checked every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_fifo_1w1r;

    localparam int DEPTH_W = 4;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 1 << DEPTH_W;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [DEPTH_W:0]   count;
    logic               overflow;
    logic               underflow;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] model_q [$];
    logic             model_ovf = 1'b0;
    logic             model_unf = 1'b0;

    fifo_1w1r #(.DEPTH_W(DEPTH_W), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after an edge; they are sampled at the next edge.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [WIDTH-1:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue updated from the FIFO's rules at each edge.
    always @(posedge clk) begin
        bit m_ready;
        bit m_valid;
        m_ready = (model_q.size() < DEPTH) && !rst && !flush;
        m_valid = (model_q.size() > 0) && !rst && !flush;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            if (in_valid && model_q.size() == DEPTH) model_ovf = 1'b1;
            if (out_ready && model_q.size() == 0 && !flush) model_unf = 1'b1;
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_valid && out_ready) void'(model_q.pop_front());
                if (m_ready && in_valid) model_q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        exp_ready = (model_q.size() < DEPTH) && !rst && !flush;
        exp_valid = (model_q.size() > 0) && !rst && !flush;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("overflow", 32'(overflow), 32'(model_ovf));
        checkOutput("underflow", 32'(underflow), 32'(model_unf));
        if (exp_valid) checkOutput("out_data", out_data, model_q[0]);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("lit_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("lit_rst_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("lit_rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("lit_rel_count", 32'(count), 32'd0);
        checkOutput("lit_rel_flags", {30'd0, overflow, underflow}, 32'd0);

        applyStimulus(0, 0, 1, 32'h11, 0);
        applyStimulus(0, 0, 1, 32'h22, 0);
        applyStimulus(0, 0, 1, 32'h33, 0);
        checkOutput("lit_t1_count", 32'(count), 32'd3);
        checkOutput("lit_t1_model_count", 32'(model_q.size()), 32'd3);
        checkOutput("lit_t1_head", out_data, 32'h11);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("lit_t1_drained_count", 32'(count), 32'd0);
        checkOutput("lit_t1_drained_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 32'(i), 0);
        checkOutput("lit_t2_full_ready", 32'(in_ready), 32'd0);
        checkOutput("lit_t2_full_count", 32'(count), 32'd16);
        applyStimulus(0, 0, 1, 32'hEE, 0);
        checkOutput("lit_t2_overflow", 32'(overflow), 32'd1);
        checkOutput("lit_t2_count_held", 32'(count), 32'd16);
        checkOutput("lit_t2_head", out_data, 32'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("lit_t2_model_empty", 32'(model_q.size()), 32'd0);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 32'h100 + 32'(i), 0);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 32'h200 + 32'(i), 1);
        checkOutput("lit_t3_count", 32'(count), 32'd8);
        checkOutput("lit_t3_model_head", model_q[0], 32'h220);
        checkOutput("lit_t3_head", out_data, 32'h220);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("lit_t4_empty", 32'(count), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("lit_t4_underflow", 32'(underflow), 32'd1);
        checkOutput("lit_t4_count", 32'(count), 32'd0);
        applyStimulus(0, 0, 1, 32'hAB, 0);
        checkOutput("lit_t4_valid", 32'(out_valid), 32'd1);
        checkOutput("lit_t4_data", out_data, 32'hAB);

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'hC0 + 32'(i), 0);
        checkOutput("lit_t5_preload", 32'(count), 32'd5);
        applyStimulus(0, 1, 1, 32'hDD, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("lit_t5_count", 32'(count), 32'd0);
        checkOutput("lit_t5_valid", 32'(out_valid), 32'd0);
        checkOutput("lit_t5_flags", {30'd0, overflow, underflow}, 32'd3);
        applyStimulus(0, 0, 1, 32'h5A, 0);
        checkOutput("lit_t5_data", out_data, 32'h5A);

        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 32'h300 + 32'(i), 0);
        checkOutput("lit_t6_count", 32'(count), 32'd10);
        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("lit_t6_rst_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("lit_t6_count", 32'(count), 32'd0);
        checkOutput("lit_t6_overflow", 32'(overflow), 32'd0);
        checkOutput("lit_t6_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 1, 32'h77, 0);
        checkOutput("lit_t6_data", out_data, 32'h77);
        applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
